// File: rtl/tlp_ingress_arbiter_if.sv
// Stream bundle for the TLP ingress arbiter: NUM_REQ AXI4-Stream sources on the
// requester side and one merged AXI4-Stream toward the AXI-to-OCP translation block.
// The "master" modport is the arbiter's view. The "slave" modport is the
// environment's view: the requesters plus the downstream sink.
interface tlp_ingress_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]          s_axis_tvalid;
  logic [NUM_REQ-1:0]          s_axis_tready;
  logic [NUM_REQ*DATA_W-1:0]   s_axis_tdata;
  logic [NUM_REQ*DATA_W/8-1:0] s_axis_tkeep;
  logic [NUM_REQ-1:0]          s_axis_tlast;

  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [DATA_W-1:0]           m_axis_tdata;
  logic [DATA_W/8-1:0]         m_axis_tkeep;
  logic                        m_axis_tlast;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );
endinterface

// File: rtl/tlp_ingress_arbiter.sv
// Packet-atomic round-robin arbiter merging TLP source streams (0=completions,
// 1=posted, 2=non-posted) onto one AXI4-Stream. The grant is held from the first
// beat through tlast, so TLPs are never interleaved.
// Optional build macro TLP_CPL_PRIORITY_EN: completions (requester 0) win every
// arbitration in which they are valid; the rr pointer still orders the others.
module tlp_ingress_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  tlp_ingress_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] sel_oh;
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   rr_after_g;

  logic               m_tvalid_c;
  logic [DATA_W-1:0]  m_tdata_c;
  logic [KEEP_W-1:0]  m_tkeep_c;
  logic               m_tlast_c;
  logic [NUM_REQ-1:0] s_tready_c;

  // Pick the first valid requester at or above the rr pointer, wrapping around.
  always_comb begin
    sel_oh    = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_idx = PTR_W'((int'(rr_q) + k) % NUM_REQ);
      if (!sel_found && bus.s_axis_tvalid[sel_idx]) begin
        sel_found       = 1'b1;
        sel_oh[sel_idx] = 1'b1;
      end
    end
`ifdef TLP_CPL_PRIORITY_EN
    // Completions must never wait behind non-posted traffic.
    if (bus.s_axis_tvalid[0]) begin
      sel_oh = NUM_REQ'(1);
    end
`endif
  end

  // Pass the granted requester straight through; everything is zero while idle.
  always_comb begin
    m_tvalid_c = 1'b0;
    m_tdata_c  = '0;
    m_tkeep_c  = '0;
    m_tlast_c  = 1'b0;
    s_tready_c = '0;
    rr_after_g = rr_q;
    if (state_q == S_XFER) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          m_tvalid_c    = bus.s_axis_tvalid[i];
          m_tdata_c     = bus.s_axis_tdata[i*DATA_W +: DATA_W];
          m_tkeep_c     = bus.s_axis_tkeep[i*KEEP_W +: KEEP_W];
          m_tlast_c     = bus.s_axis_tlast[i];
          s_tready_c[i] = bus.m_axis_tready;
          rr_after_g    = PTR_W'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  // Grant on any request in IDLE; release and rotate the pointer on the tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.s_axis_tvalid) begin
          state_d = S_XFER;
          grant_d = sel_oh;
          busy_d  = 1'b1;
        end
      end
      S_XFER: begin
        if (m_tvalid_c && bus.m_axis_tready && m_tlast_c) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          rr_d    = rr_after_g;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state; a reset drops any in-flight packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_axis_tvalid = m_tvalid_c;
  assign bus.m_axis_tdata  = m_tdata_c;
  assign bus.m_axis_tkeep  = m_tkeep_c;
  assign bus.m_axis_tlast  = m_tlast_c;
  assign bus.s_axis_tready = s_tready_c;

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_tlp_ingress_arbiter.sv
// Self-checking bench for tlp_ingress_arbiter: per-requester packet drivers,
// a negedge monitor of accepted output beats, and a scoreboard of expected beats.
module tb_tlp_ingress_arbiter;
  localparam int NR = 3;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [NR-1:0] g;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] grant;
  logic          busy;
  logic [15:0]   pkt_count;

  logic          src_valid [NR];
  logic [DW-1:0] src_data  [NR];
  logic [KW-1:0] src_keep  [NR];
  logic          src_last  [NR];
  logic          m_ready;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_assert;
  int    n_fail;

  always #5 clk = ~clk;

  tlp_ingress_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  tlp_ingress_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      bus.s_axis_tvalid[i]            = src_valid[i];
      bus.s_axis_tdata[i*DW +: DW]    = src_data[i];
      bus.s_axis_tkeep[i*KW +: KW]    = src_keep[i];
      bus.s_axis_tlast[i]             = src_last[i];
    end
    bus.m_axis_tready = m_ready;
  end

  // Record every beat accepted by the sink (stable from negedge to the next posedge).
  always @(negedge clk) begin
    beat_t b;
    if (reset_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
      b.g = grant;
      b.d = bus.m_axis_tdata;
      b.k = bus.m_axis_tkeep;
      b.l = bus.m_axis_tlast;
      obs_q.push_back(b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] base, input int b);
    return base + DW'(b) * 64'h1111_1111_1111_1111;
  endfunction

  function automatic logic [KW-1:0] beat_keep(input int nb, input int b);
    return (b == nb - 1) ? 8'h0F : 8'hFF;
  endfunction

  task automatic push_exp(input int r, input int nb, input logic [DW-1:0] base);
    beat_t e;
    for (int b = 0; b < nb; b++) begin
      e.g = NR'(1) << r;
      e.d = beat_data(base, b);
      e.k = beat_keep(nb, b);
      e.l = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_pkt(input int r, input int nb, input logic [DW-1:0] base,
                           input int gap_at, input int gap_len);
    int t;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_at && gap_len > 0) begin
        src_valid[r] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      src_valid[r] = 1'b1;
      src_data[r]  = beat_data(base, b);
      src_keep[r]  = beat_keep(nb, b);
      src_last[r]  = (b == nb - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!bus.s_axis_tready[r] && t < 200);
      if (!bus.s_axis_tready[r]) begin
        n_assert++;
        n_fail++;
        $display("FAIL handshake_timeout req%0d beat%0d: tready=%b required 1", r, b, bus.s_axis_tready[r]);
        break;
      end
      @(posedge clk);
      #1;
    end
    src_valid[r] = 1'b0;
    src_last[r]  = 1'b0;
    src_data[r]  = '0;
    src_keep[r]  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_valid[i] = 1'b0;
      src_data[i]  = '0;
      src_keep[i]  = '0;
      src_last[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_valid[i] = 1'b1;
      src_data[i]  = 64'hDEAD_0000_0000_0000 + DW'(i);
      src_keep[i]  = 8'hFF;
      src_last[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_assert += 5;
    if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b required 000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (pkt_count !== 16'h0000) begin n_fail++; $display("FAIL reset_pkt_count: got %h required 0000", pkt_count); end
    if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b required 0", bus.m_axis_tvalid); end
    if (bus.s_axis_tready !== 3'b000) begin n_fail++; $display("FAIL reset_s_tready: got %b required 000", bus.s_axis_tready); end
    for (int i = 0; i < NR; i++) src_valid[i] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_assert += 2;
    if (grant !== 3'b000) begin n_fail++; $display("FAIL idle_grant: got %b required 000", grant); end
    if (bus.m_axis_tdata !== 64'h0) begin n_fail++; $display("FAIL idle_m_tdata: got %h required 0", bus.m_axis_tdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pkt();
    beat_t o, e;
    do_reset();
    push_exp(1, 3, 64'h1111_1111_1111_1111);
    fork
      drive_pkt(1, 3, 64'h1111_1111_1111_1111, -1, 0);
      begin
        @(negedge clk);
        n_assert++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL single_arb_latency: grant=%b required 000", grant); end
        @(negedge clk);
        n_assert += 2;
        if (grant !== 3'b010) begin n_fail++; $display("FAIL single_grant: grant=%b required 010", grant); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: busy=%b required 1", busy); end
      end
    join
    @(negedge clk);
    n_assert += 3;
    if (grant !== 3'b000) begin n_fail++; $display("FAIL single_grant_release: grant=%b required 000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_release: busy=%b required 0", busy); end
    if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_pkt_count: got %0d required 1", pkt_count); end
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL single_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    beat_t o, e;
    do_reset();
    push_exp(0, 2, 64'h0A00_0000_0000_0000);
    push_exp(1, 2, 64'h0B00_0000_0000_0000);
    push_exp(2, 2, 64'h0C00_0000_0000_0000);
    push_exp(0, 2, 64'h0D00_0000_0000_0000);
    fork
      begin
        drive_pkt(0, 2, 64'h0A00_0000_0000_0000, -1, 0);
        drive_pkt(0, 2, 64'h0D00_0000_0000_0000, -1, 0);
      end
      drive_pkt(1, 2, 64'h0B00_0000_0000_0000, -1, 0);
      drive_pkt(2, 2, 64'h0C00_0000_0000_0000, -1, 0);
    join
    @(negedge clk);
    n_assert += 2;
    if (pkt_count !== 16'd4) begin n_fail++; $display("FAIL fair_pkt_count: got %0d required 4", pkt_count); end
    if (grant !== 3'b000) begin n_fail++; $display("FAIL fair_grant_release: grant=%b required 000", grant); end
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fair_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL fair_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    beat_t o, e;
    logic          stall;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    do_reset();
    m_ready = 1'b0;
    stall   = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    push_exp(0, 4, 64'h5000_0000_0000_0000);
    fork
      drive_pkt(0, 4, 64'h5000_0000_0000_0000, -1, 0);
      begin
        for (int c = 0; c < 24; c++) begin
          @(negedge clk);
          if (stall) begin
            n_assert += 3;
            if (bus.m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid_hold: got %b required 1", bus.m_axis_tvalid); end
            if (bus.m_axis_tdata !== hold_d) begin n_fail++; $display("FAIL bp_tdata_hold: got %h required %h", bus.m_axis_tdata, hold_d); end
            if (bus.m_axis_tlast !== hold_l) begin n_fail++; $display("FAIL bp_tlast_hold: got %b required %b", bus.m_axis_tlast, hold_l); end
          end
          n_assert++;
          if (bus.s_axis_tready !== (busy ? {2'b00, m_ready} : 3'b000)) begin
            n_fail++;
            $display("FAIL bp_s_tready: got %b required %b", bus.s_axis_tready, (busy ? {2'b00, m_ready} : 3'b000));
          end
          stall  = bus.m_axis_tvalid && !m_ready;
          hold_d = bus.m_axis_tdata;
          hold_l = bus.m_axis_tlast;
          @(posedge clk);
          #1;
          m_ready = ~m_ready;
        end
        m_ready = 1'b1;
      end
    join
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL bp_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_src_gap();
    beat_t o, e;
    do_reset();
    push_exp(0, 4, 64'h6000_0000_0000_0000);
    push_exp(2, 2, 64'h7000_0000_0000_0000);
    fork
      drive_pkt(0, 4, 64'h6000_0000_0000_0000, 2, 5);
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_pkt(2, 2, 64'h7000_0000_0000_0000, -1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          n_assert += 3;
          if (grant !== 3'b001) begin n_fail++; $display("FAIL gap_grant_hold: grant=%b required 001", grant); end
          if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL gap_m_tvalid: got %b required 0", bus.m_axis_tvalid); end
          if (bus.s_axis_tready[2] !== 1'b0) begin n_fail++; $display("FAIL gap_req2_ready: got %b required 0", bus.s_axis_tready[2]); end
        end
      end
    join
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gap_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL gap_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pkt();
    beat_t o, e;
    do_reset();
    drive_pkt(0, 1, 64'h8000_0000_0000_0000, -1, 0);
    src_valid[1] = 1'b1;
    src_data[1]  = 64'h8100_0000_0000_0000;
    src_keep[1]  = 8'hFF;
    src_last[1]  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert += 3;
    if (grant !== 3'b010) begin n_fail++; $display("FAIL midrst_pre_grant: grant=%b required 010", grant); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: busy=%b required 1", busy); end
    if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL midrst_pre_count: got %0d required 1", pkt_count); end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_assert += 5;
    if (grant !== 3'b000) begin n_fail++; $display("FAIL midrst_grant: grant=%b required 000", grant); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: busy=%b required 0", busy); end
    if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d required 0", pkt_count); end
    if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_tvalid: got %b required 0", bus.m_axis_tvalid); end
    if (bus.s_axis_tready !== 3'b000) begin n_fail++; $display("FAIL midrst_s_tready: got %b required 000", bus.s_axis_tready); end
    src_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    push_exp(0, 2, 64'h9000_0000_0000_0000);
    push_exp(1, 2, 64'h9100_0000_0000_0000);
    fork
      drive_pkt(0, 2, 64'h9000_0000_0000_0000, -1, 0);
      drive_pkt(1, 2, 64'h9100_0000_0000_0000, -1, 0);
    join
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL midrst_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_priority();
    beat_t o, e;
    do_reset();
    push_exp(0, 1, 64'hA000_0000_0000_0000);
    drive_pkt(0, 1, 64'hA000_0000_0000_0000, -1, 0);
`ifdef TLP_CPL_PRIORITY_EN
    push_exp(0, 2, 64'hB000_0000_0000_0000);
    push_exp(1, 2, 64'hB100_0000_0000_0000);
`else
    push_exp(1, 2, 64'hB100_0000_0000_0000);
    push_exp(0, 2, 64'hB000_0000_0000_0000);
`endif
    fork
      drive_pkt(0, 2, 64'hB000_0000_0000_0000, -1, 0);
      drive_pkt(1, 2, 64'hB100_0000_0000_0000, -1, 0);
    join
    @(negedge clk);
    n_assert++;
    if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL prio_pkt_count: got %0d required 3", pkt_count); end
    n_assert++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL prio_beat_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL prio_beat: got g=%b d=%h k=%h l=%b required g=%b d=%h k=%h l=%b", o.g, o.d, o.k, o.l, e.g, e.d, e.k, e.l); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    m_ready  = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_valid[i] = 1'b0;
      src_data[i]  = '0;
      src_keep[i]  = '0;
      src_last[i]  = 1'b0;
    end
    test_reset();
    test_single_pkt();
    test_fairness();
    test_backpressure();
    test_src_gap();
    test_reset_mid_pkt();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
